// File: rtl/hazard_scoreboard.sv
// Forwarding and interlock unit for the 5-stage pipeline, with a single-entry
// mul/div scoreboard, result-bus forwarding and a saturating stall counter.
module hazard_scoreboard #(
    parameter int AW     = 5,
    parameter int MD_LAT = 4,
    parameter int CNT_W  = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [AW-1:0]    id_rs,
    input  logic [AW-1:0]    id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             id_branch,
    input  logic             id_md,
    input  logic [AW-1:0]    ex_rs,
    input  logic [AW-1:0]    ex_rt,
    input  logic             ex_regwrite,
    input  logic             ex_memread,
    input  logic [AW-1:0]    ex_rd,
    input  logic             mem_regwrite,
    input  logic             mem_memread,
    input  logic [AW-1:0]    mem_rd,
    input  logic             wb_regwrite,
    input  logic [AW-1:0]    wb_rd,
    input  logic             md_issue,
    input  logic [AW-1:0]    md_rd,
    output logic [1:0]       fwd_a_id,
    output logic [1:0]       fwd_b_id,
    output logic [1:0]       fwd_a_ex,
    output logic [1:0]       fwd_b_ex,
    output logic             stall,
    output logic             md_busy,
    output logic             md_done,
    output logic [AW-1:0]    md_wb_rd,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int CW = $clog2(MD_LAT);

    logic [CW-1:0] mdCnt;

    // Register 0 is hardwired zero, so a write to it is never a producer.
    function automatic logic hit(input logic we, input logic [AW-1:0] rd,
                                 input logic [AW-1:0] src);
        return we && (rd != '0) && (rd == src);
    endfunction

    function automatic logic [1:0] exSel(input logic [AW-1:0] src,
                                         input logic memHit, input logic wbHit);
        if (memHit)     return 2'b01;
        else if (wbHit) return 2'b10;
        else            return 2'b00;
    endfunction

    function automatic logic [1:0] idSel(input logic useSrc, input logic mdHit,
                                         input logic memHit, input logic memLoad,
                                         input logic wbHit);
        if (!useSrc)                 return 2'b00;
        else if (mdHit)              return 2'b11;
        else if (memHit && !memLoad) return 2'b01;
        else if (wbHit)              return 2'b10;
        else                         return 2'b00;
    endfunction

    logic rsEx, rtEx, rsMem, rtMem, rsWb, rtWb, rsMd, rtMd;
    logic mdPending, loadUse, branchHaz, scoreRaw, structural;

    assign rsEx  = id_use_rs && hit(ex_regwrite, ex_rd, id_rs);
    assign rtEx  = id_use_rt && hit(ex_regwrite, ex_rd, id_rt);
    assign rsMem = id_use_rs && hit(mem_regwrite, mem_rd, id_rs);
    assign rtMem = id_use_rt && hit(mem_regwrite, mem_rd, id_rt);
    assign rsWb  = id_use_rs && hit(wb_regwrite, wb_rd, id_rs);
    assign rtWb  = id_use_rt && hit(wb_regwrite, wb_rd, id_rt);
    assign rsMd  = id_use_rs && hit(1'b1, md_wb_rd, id_rs);
    assign rtMd  = id_use_rt && hit(1'b1, md_wb_rd, id_rt);

    assign fwd_a_ex = exSel(ex_rs, hit(mem_regwrite, mem_rd, ex_rs), hit(wb_regwrite, wb_rd, ex_rs));
    assign fwd_b_ex = exSel(ex_rt, hit(mem_regwrite, mem_rd, ex_rt), hit(wb_regwrite, wb_rd, ex_rt));
    assign fwd_a_id = idSel(id_use_rs, md_done && rsMd, rsMem, mem_memread, rsWb);
    assign fwd_b_id = idSel(id_use_rt, md_done && rtMd, rtMem, mem_memread, rtWb);

    // In the done cycle the result is on the bus, so waiting consumers are released.
    assign md_done    = md_busy && (mdCnt == '0);
    assign mdPending  = md_busy && !md_done;
    assign loadUse    = ex_memread && (rsEx || rtEx);
    assign branchHaz  = id_branch && (rsEx || rtEx || (mem_memread && (rsMem || rtMem)));
    assign scoreRaw   = mdPending && (rsMd || rtMd);
    assign structural = id_md && mdPending;
    assign stall      = loadUse || branchHaz || scoreRaw || structural;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            md_busy  <= 1'b0;
            mdCnt    <= '0;
            md_wb_rd <= '0;
        end else if (md_issue) begin
            md_busy  <= 1'b1;
            mdCnt    <= CW'(MD_LAT - 1);
            md_wb_rd <= md_rd;
        end else if (md_busy) begin
            if (mdCnt != '0) mdCnt <= mdCnt - CW'(1);
            else             md_busy <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            stall_cnt <= '0;
        else if (stall && (stall_cnt != '1))
            stall_cnt <= stall_cnt + CNT_W'(1);
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard (AW=5, MD_LAT=4, CNT_W=4) with
// hand-computed expectations checked by immediate assertions.
module tb_hazard_scoreboard;

    localparam int AW     = 5;
    localparam int MD_LAT = 4;
    localparam int CNT_W  = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd, md_rd;
    logic          id_use_rs, id_use_rt, id_branch, id_md;
    logic          ex_regwrite, ex_memread, mem_regwrite, mem_memread, wb_regwrite, md_issue;
    logic [1:0]    fwd_a_id, fwd_b_id, fwd_a_ex, fwd_b_ex;
    logic          stall, md_busy, md_done;
    logic [AW-1:0] md_wb_rd;
    logic [CNT_W-1:0] stall_cnt;

    int checks   = 0;
    int failures = 0;

    hazard_scoreboard #(.AW(AW), .MD_LAT(MD_LAT), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_branch(id_branch), .id_md(id_md),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
        .ex_rd(ex_rd), .mem_regwrite(mem_regwrite), .mem_memread(mem_memread),
        .mem_rd(mem_rd), .wb_regwrite(wb_regwrite), .wb_rd(wb_rd),
        .md_issue(md_issue), .md_rd(md_rd),
        .fwd_a_id(fwd_a_id), .fwd_b_id(fwd_b_id), .fwd_a_ex(fwd_a_ex), .fwd_b_ex(fwd_b_ex),
        .stall(stall), .md_busy(md_busy), .md_done(md_done), .md_wb_rd(md_wb_rd),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and step just past it; inputs change here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clearIn();
        id_rs = '0; id_rt = '0; id_use_rs = 0; id_use_rt = 0; id_branch = 0; id_md = 0;
        ex_rs = '0; ex_rt = '0; ex_regwrite = 0; ex_memread = 0; ex_rd = '0;
        mem_regwrite = 0; mem_memread = 0; mem_rd = '0;
        wb_regwrite = 0; wb_rd = '0; md_issue = 0; md_rd = '0;
    endtask

    initial begin
        reset = 1'b0;
        clearIn();
        tick();
        tick();
        check("rst_busy", md_busy, 0);
        check("rst_done", md_done, 0);
        check("rst_wb_rd", md_wb_rd, 0);
        check("rst_cnt", stall_cnt, 0);
        check("rst_stall", stall, 0);
        reset = 1'b1;
        tick();

        // ALU RAW forwarding into EX
        mem_regwrite = 1; mem_rd = 5; wb_regwrite = 1; wb_rd = 5; ex_rt = 5;
        settle();
        check("ex_b_mem_wins", fwd_b_ex, 2'b01);
        check("ex_a_none", fwd_a_ex, 2'b00);
        mem_regwrite = 0;
        settle();
        check("ex_b_wb", fwd_b_ex, 2'b10);
        mem_regwrite = 1; mem_rd = 0; wb_rd = 0; ex_rt = 0;
        settle();
        check("ex_b_r0", fwd_b_ex, 2'b00);
        ex_rs = 7; wb_rd = 7;
        settle();
        check("ex_a_wb", fwd_a_ex, 2'b10);
        check("alu_no_stall", stall, 0);

        // Load-use interlock
        clearIn();
        ex_regwrite = 1; ex_memread = 1; ex_rd = 8; id_rs = 8; id_use_rs = 1;
        settle();
        check("lu_stall", stall, 1);
        tick();
        check("lu_cnt", stall_cnt, 1);
        id_use_rs = 0;
        settle();
        check("lu_unused", stall, 0);
        tick();
        check("lu_cnt_hold", stall_cnt, 1);

        // Branch resolved in ID
        clearIn();
        id_branch = 1; id_use_rt = 1; id_rt = 3; ex_regwrite = 1; ex_rd = 3;
        settle();
        check("br_ex_stall", stall, 1);
        tick();
        check("br_cnt", stall_cnt, 2);
        ex_regwrite = 0; mem_regwrite = 1; mem_rd = 3;
        settle();
        check("br_mem_stall", stall, 0);
        check("br_mem_fwd", fwd_b_id, 2'b01);
        mem_memread = 1;
        settle();
        check("br_load_stall", stall, 1);
        check("br_load_fwd", fwd_b_id, 2'b00);
        tick();
        check("br_cnt2", stall_cnt, 3);
        clearIn();
        id_use_rs = 1; id_rs = 6; ex_regwrite = 1; ex_rd = 6; wb_regwrite = 1; wb_rd = 6;
        settle();
        check("nobr_ex_nostall", stall, 0);
        check("id_a_wb", fwd_a_id, 2'b10);

        // Mul/div scoreboard RAW and result-bus forward
        clearIn();
        md_issue = 1; md_rd = 9; id_rs = 9; id_use_rs = 1;
        settle();
        check("md_pre_stall", stall, 0);
        check("md_pre_busy", md_busy, 0);
        tick();
        md_issue = 0;
        settle();
        check("md_c0_busy", md_busy, 1);
        check("md_c0_wb_rd", md_wb_rd, 9);
        check("md_c0_stall", stall, 1);
        tick();
        check("md_c1_stall", stall, 1);
        check("md_c1_done", md_done, 0);
        tick();
        check("md_c2_stall", stall, 1);
        check("md_c2_done", md_done, 0);
        tick();
        check("md_c3_done", md_done, 1);
        check("md_c3_stall", stall, 0);
        check("md_c3_fwd", fwd_a_id, 2'b11);
        tick();
        check("md_c4_busy", md_busy, 0);
        check("md_c4_done", md_done, 0);
        check("md_c4_fwd", fwd_a_id, 2'b00);
        check("md_cnt", stall_cnt, 6);

        // Structural hazard and back-to-back issue in the done cycle
        clearIn();
        id_md = 1; md_issue = 1; md_rd = 10;
        tick();
        md_issue = 0;
        settle();
        check("st_f0_stall", stall, 1);
        tick();
        tick();
        check("st_f2_stall", stall, 1);
        tick();
        check("st_f3_done", md_done, 1);
        check("st_f3_stall", stall, 0);
        check("st_f3_wb_rd", md_wb_rd, 10);
        md_issue = 1; md_rd = 11;
        tick();
        md_issue = 0;
        settle();
        check("b2b_busy", md_busy, 1);
        check("b2b_wb_rd", md_wb_rd, 11);
        check("b2b_done", md_done, 0);
        check("b2b_stall", stall, 1);
        tick();
        tick();
        check("b2b_f6_done", md_done, 0);
        tick();
        check("b2b_f7_done", md_done, 1);
        id_md = 0;
        tick();
        check("b2b_idle", md_busy, 0);
        check("b2b_cnt", stall_cnt, 12);

        // Destination r0: timed, but no RAW stall and no forward
        clearIn();
        md_issue = 1; md_rd = 0; id_use_rs = 1; id_rs = 0;
        tick();
        md_issue = 0;
        settle();
        check("r0_busy", md_busy, 1);
        check("r0_stall", stall, 0);
        tick();
        tick();
        tick();
        check("r0_done", md_done, 1);
        check("r0_fwd", fwd_a_id, 2'b00);
        tick();
        check("r0_idle", md_busy, 0);

        // Reset asserted mid-op drops it
        clearIn();
        md_issue = 1; md_rd = 12; id_use_rs = 1; id_rs = 12;
        tick();
        md_issue = 0;
        tick();
        check("rm_pre_stall", stall, 1);
        reset = 1'b0;
        settle();
        check("rm_busy", md_busy, 0);
        check("rm_done", md_done, 0);
        check("rm_wb_rd", md_wb_rd, 0);
        check("rm_cnt", stall_cnt, 0);
        check("rm_stall", stall, 0);
        tick();
        tick();
        reset = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("rm_no_done", md_done, 0);
        end

        // Saturation of the 4-bit stall counter
        clearIn();
        ex_regwrite = 1; ex_memread = 1; ex_rd = 4; id_rt = 4; id_use_rt = 1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            check("sat_cnt", stall_cnt, (k > 15) ? 15 : k);
        end
        clearIn();
        tick();
        check("sat_hold", stall_cnt, 15);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
